// File: rtl/mmu_pkg.sv
// Shared MMU definitions: translation-arbiter state encoding and 68k function codes.
package mmu_pkg;

  typedef enum logic [1:0] {
    XARB_IDLE   = 2'd0,
    XARB_LOOKUP = 2'd1,
    XARB_WALK   = 2'd2,
    XARB_RESP   = 2'd3
  } xarb_state_t;

  localparam logic [2:0] FC_USER_DATA = 3'b001;
  localparam logic [2:0] FC_USER_PROG = 3'b010;
  localparam logic [2:0] FC_SUP_DATA  = 3'b101;
  localparam logic [2:0] FC_SUP_PROG  = 3'b110;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; purely combinational, grant is one-hot or zero.
// On contention the requester not granted last wins; last=1 means r1 went last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/mmu_xlate_arb.sv
// Shares the MMU lookup port between fetch (r0) and data (r1); ack MMU_LAT+2 cycles after req.
// Requesters hold req until ack; a miss stalls in WALK until walk_done, then relooks up.
module mmu_xlate_arb
  import mmu_pkg::*;
#(
  parameter int VA_WIDTH  = 24,
  parameter int PA_WIDTH  = 24,
  parameter int MMU_LAT   = 1,
  parameter int MAX_WALKS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                r0_req,
  input  logic [VA_WIDTH-1:0] r0_va,
  input  logic [2:0]          r0_fc,
  input  logic                r0_rw_n,
  input  logic                r1_req,
  input  logic [VA_WIDTH-1:0] r1_va,
  input  logic [2:0]          r1_fc,
  input  logic                r1_rw_n,
  output logic                r0_ack,
  output logic                r1_ack,
  output logic [PA_WIDTH-1:0] rsp_pa,
  output logic                rsp_fault,
  output logic [VA_WIDTH-1:0] mmu_va,
  output logic [2:0]          mmu_fc,
  output logic                mmu_rw_n,
  input  logic [PA_WIDTH-1:0] mmu_pa,
  input  logic                mmu_hit,
  input  logic                mmu_fault,
  output logic                walk_req,
  input  logic                walk_done,
  output logic                busy
);

  localparam int LW = $clog2(MMU_LAT + 1);
  localparam int WW = $clog2(MAX_WALKS + 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(MMU_LAT);
  localparam logic [WW-1:0] WALK_MAX = WW'(MAX_WALKS);

  xarb_state_t   state;
  logic [LW-1:0] lat_cnt;
  logic [WW-1:0] walk_cnt;
  logic          gnt_idx;
  logic          last_grant;
  logic [1:0]    grant;

  rr_arb2 u_rr_arb2 (
    .req   ({r1_req, r0_req}),
    .last  (last_grant),
    .grant (grant)
  );

  // The mmu_* registers double as the capture registers: loaded only in IDLE,
  // held through LOOKUP and WALK, and parked at the idle pattern on entry to RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= XARB_IDLE;
      lat_cnt    <= '0;
      walk_cnt   <= '0;
      gnt_idx    <= 1'b0;
      last_grant <= 1'b1;
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
      rsp_pa     <= '0;
      rsp_fault  <= 1'b0;
      mmu_va     <= '0;
      mmu_fc     <= 3'b000;
      mmu_rw_n   <= 1'b1;
      walk_req   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      case (state)
        XARB_IDLE: begin
          if (|grant) begin
            gnt_idx  <= grant[1];
            mmu_va   <= grant[1] ? r1_va   : r0_va;
            mmu_fc   <= grant[1] ? r1_fc   : r0_fc;
            mmu_rw_n <= grant[1] ? r1_rw_n : r0_rw_n;
            lat_cnt  <= '0;
            walk_cnt <= '0;
            busy     <= 1'b1;
            state    <= XARB_LOOKUP;
          end
        end
        XARB_LOOKUP: begin
          if (lat_cnt != LAT_LAST) begin
            lat_cnt <= lat_cnt + LW'(1);
          end else if (mmu_fault || mmu_hit || walk_cnt >= WALK_MAX) begin
            // Fault wins over hit; an exhausted miss is reported as a fault with pa 0.
            rsp_fault <= mmu_fault || !mmu_hit;
            rsp_pa    <= (mmu_hit && !mmu_fault) ? mmu_pa : '0;
            r0_ack    <= !gnt_idx;
            r1_ack    <= gnt_idx;
            mmu_va    <= '0;
            mmu_fc    <= 3'b000;
            mmu_rw_n  <= 1'b1;
            state     <= XARB_RESP;
          end else begin
            walk_cnt <= walk_cnt + WW'(1);
            walk_req <= 1'b1;
            state    <= XARB_WALK;
          end
        end
        XARB_WALK: begin
          if (walk_done) begin
            walk_req <= 1'b0;
            lat_cnt  <= '0;
            state    <= XARB_LOOKUP;
          end
        end
        XARB_RESP: begin
          last_grant <= gnt_idx;
          busy       <= 1'b0;
          state      <= XARB_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= XARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_xlate_arb.sv
// Directed bench for mmu_xlate_arb: vector table for arbitration/hit/fault, hand sequences for walks and reset.
module tb_mmu_xlate_arb;
  import mmu_pkg::*;

  localparam int TXN_BUDGET = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req, r1_req;
  logic [23:0] r0_va, r1_va;
  logic [2:0]  r0_fc, r1_fc;
  logic        r0_rw_n, r1_rw_n;
  logic        r0_ack, r1_ack;
  logic [23:0] rsp_pa;
  logic        rsp_fault;
  logic [23:0] mmu_va;
  logic [2:0]  mmu_fc;
  logic        mmu_rw_n;
  logic [23:0] mmu_pa;
  logic        mmu_hit, mmu_fault;
  logic        walk_req, walk_done, busy;
  logic        hit_v, fault_v;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // MMU stand-in: translation is a fixed XOR of the upper byte.
  assign mmu_pa    = mmu_va ^ 24'h0A0000;
  assign mmu_hit   = hit_v;
  assign mmu_fault = fault_v;

  mmu_xlate_arb #(.VA_WIDTH(24), .PA_WIDTH(24), .MMU_LAT(1), .MAX_WALKS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_va(r0_va), .r0_fc(r0_fc), .r0_rw_n(r0_rw_n),
    .r1_req(r1_req), .r1_va(r1_va), .r1_fc(r1_fc), .r1_rw_n(r1_rw_n),
    .r0_ack(r0_ack), .r1_ack(r1_ack), .rsp_pa(rsp_pa), .rsp_fault(rsp_fault),
    .mmu_va(mmu_va), .mmu_fc(mmu_fc), .mmu_rw_n(mmu_rw_n),
    .mmu_pa(mmu_pa), .mmu_hit(mmu_hit), .mmu_fault(mmu_fault),
    .walk_req(walk_req), .walk_done(walk_done), .busy(busy)
  );

  typedef struct {
    logic        r0, r1;
    logic [23:0] va0; logic [2:0] fc0; logic rw0;
    logic [23:0] va1; logic [2:0] fc1; logic rw1;
    logic        hit, flt;
    logic        exp_who;
    logic [23:0] exp_pa;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Clocks a transaction to its ack, acting as table walker along the way.
  task automatic run_txn(input int walk_delay, input logic fill,
                         output int cyc, output logic a0, output logic a1,
                         output logic [23:0] pa, output logic flt,
                         output int walks, output int first_walk,
                         output logic [23:0] lva, output logic [2:0] lfc, output logic lrw);
    int wcnt;
    logic seen_busy;
    cyc = 0; walks = 0; first_walk = -1; wcnt = 0; seen_busy = 1'b0;
    a0 = 1'b0; a1 = 1'b0; pa = '0; flt = 1'b0; lva = '0; lfc = '0; lrw = 1'b0;
    while (cyc < TXN_BUDGET) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      walk_done = 1'b0;
      if (busy && !seen_busy) begin
        seen_busy = 1'b1;
        lva = mmu_va; lfc = mmu_fc; lrw = mmu_rw_n;
      end
      if (r0_ack || r1_ack) begin
        a0 = r0_ack; a1 = r1_ack; pa = rsp_pa; flt = rsp_fault;
        return;
      end
      if (walk_req) begin
        wcnt++;
        if (wcnt == 1) begin
          walks++;
          if (first_walk < 0) first_walk = cyc;
        end
        if (wcnt == walk_delay) begin
          walk_done = 1'b1;
          if (fill) hit_v = 1'b1;
        end
      end else begin
        wcnt = 0;
      end
    end
    checks++;
    failures++;
    $display("FAIL txn_timeout actual=%0d cycles required=ack", cyc);
  endtask

  initial begin
    int cyc, walks, fw;
    logic a0, a1, flt, lrw;
    logic [23:0] pa, lva;
    logic [2:0] lfc;
    bit seen;

    vecs[0] = '{1'b1, 1'b0, 24'h001234, FC_USER_DATA, 1'b1, 24'h000000, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0A1234, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 24'h000000, 3'b000, 1'b1, 24'h00ABCD, FC_SUP_DATA, 1'b0, 1'b1, 1'b0, 1'b1, 24'h0AABCD, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 24'h003000, FC_USER_PROG, 1'b1, 24'h004000, FC_SUP_PROG, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0A3000, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 24'h003000, FC_USER_PROG, 1'b1, 24'h004000, FC_SUP_PROG, 1'b0, 1'b1, 1'b0, 1'b1, 24'h0A4000, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 24'h000000, 3'b000, 1'b1, 24'h005555, FC_USER_DATA, 1'b1, 1'b1, 1'b1, 1'b1, 24'h000000, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 24'h006000, FC_SUP_DATA, 1'b0, 24'h007000, FC_USER_DATA, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0A6000, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 24'h008000, FC_SUP_PROG, 1'b1, 24'h000000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b1};

    rst_n = 1'b0;
    r0_req = 1'b0; r1_req = 1'b0; r0_va = '0; r1_va = '0;
    r0_fc = '0; r1_fc = '0; r0_rw_n = 1'b1; r1_rw_n = 1'b1;
    walk_done = 1'b0; hit_v = 1'b1; fault_v = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_acks", {30'd0, r1_ack, r0_ack}, 32'd0);
    chk("rst_rsp_pa", rsp_pa, 32'd0);
    chk("rst_rsp_fault", rsp_fault, 32'd0);
    chk("rst_walk_req", walk_req, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_mmu_va", mmu_va, 32'd0);
    chk("rst_mmu_fc", mmu_fc, 32'd0);
    chk("rst_mmu_rw_n", mmu_rw_n, 32'd1);
    rst_n = 1'b1;

    // Both requesters held high from reset: r0, r1, r0 with back-to-back spacing.
    r0_req = 1'b1; r0_va = 24'h000100; r0_fc = FC_USER_PROG;
    r1_req = 1'b1; r1_va = 24'h000200; r1_fc = FC_USER_DATA;
    run_txn(5, 1'b0, cyc, a0, a1, pa, flt, walks, fw, lva, lfc, lrw);
    chk("cont1_who", {30'd0, a1, a0}, 32'd1);
    chk("cont1_lat", cyc, 32'd3);
    chk("cont1_pa", pa, 32'h0A0100);
    run_txn(5, 1'b0, cyc, a0, a1, pa, flt, walks, fw, lva, lfc, lrw);
    chk("cont2_who", {30'd0, a1, a0}, 32'd2);
    chk("cont2_spacing", cyc, 32'd4);
    chk("cont2_pa", pa, 32'h0A0200);
    run_txn(5, 1'b0, cyc, a0, a1, pa, flt, walks, fw, lva, lfc, lrw);
    chk("cont3_who", {30'd0, a1, a0}, 32'd1);
    chk("cont3_spacing", cyc, 32'd4);
    r0_req = 1'b0; r1_req = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      r0_req = vecs[i].r0; r0_va = vecs[i].va0; r0_fc = vecs[i].fc0; r0_rw_n = vecs[i].rw0;
      r1_req = vecs[i].r1; r1_va = vecs[i].va1; r1_fc = vecs[i].fc1; r1_rw_n = vecs[i].rw1;
      hit_v = vecs[i].hit; fault_v = vecs[i].flt;
      run_txn(5, 1'b0, cyc, a0, a1, pa, flt, walks, fw, lva, lfc, lrw);
      r0_req = 1'b0; r1_req = 1'b0;
      chk($sformatf("vec%0d_who", i), {30'd0, a1, a0}, vecs[i].exp_who ? 32'd2 : 32'd1);
      chk($sformatf("vec%0d_lat", i), cyc, 32'd3);
      chk($sformatf("vec%0d_fault", i), flt, {31'd0, vecs[i].exp_fault});
      if (!vecs[i].exp_fault) chk($sformatf("vec%0d_pa", i), pa, {8'd0, vecs[i].exp_pa});
      chk($sformatf("vec%0d_mmu_va", i), lva, {8'd0, vecs[i].exp_who ? vecs[i].va1 : vecs[i].va0});
      chk($sformatf("vec%0d_mmu_fc", i), lfc, {29'd0, vecs[i].exp_who ? vecs[i].fc1 : vecs[i].fc0});
      chk($sformatf("vec%0d_mmu_rw_n", i), lrw, {31'd0, vecs[i].exp_who ? vecs[i].rw1 : vecs[i].rw0});
      @(negedge clk);
      chk($sformatf("vec%0d_idle_busy", i), busy, 32'd0);
      chk($sformatf("vec%0d_idle_mmu", i), {mmu_va, 4'd0, mmu_fc, mmu_rw_n}, 32'd1);
    end
    fault_v = 1'b0;

    // Miss, one walk of five cycles, then a hit on the retry.
    hit_v = 1'b0;
    r0_req = 1'b1; r0_va = 24'h00F00D; r0_fc = FC_SUP_PROG; r0_rw_n = 1'b1;
    run_txn(5, 1'b1, cyc, a0, a1, pa, flt, walks, fw, lva, lfc, lrw);
    r0_req = 1'b0;
    chk("walk1_first_walk_cycle", fw, 32'd3);
    chk("walk1_walks", walks, 32'd1);
    chk("walk1_ack_cycle", cyc, fw + 7);
    chk("walk1_who", {30'd0, a1, a0}, 32'd1);
    chk("walk1_pa", pa, 32'h0AF00D);
    chk("walk1_fault", flt, 32'd0);
    @(negedge clk);

    // Persistent miss: exactly MAX_WALKS walks, then a forced fault.
    hit_v = 1'b0;
    r0_req = 1'b1; r0_va = 24'h00BEEF; r0_fc = FC_USER_DATA;
    run_txn(2, 1'b0, cyc, a0, a1, pa, flt, walks, fw, lva, lfc, lrw);
    r0_req = 1'b0;
    chk("exh_walks", walks, 32'd2);
    chk("exh_ack_cycle", cyc, 32'd11);
    chk("exh_who", {30'd0, a1, a0}, 32'd1);
    chk("exh_fault", flt, 32'd1);
    chk("exh_pa", pa, 32'd0);
    @(negedge clk);

    // Reset asserted while a walk is pending.
    hit_v = 1'b0;
    r0_req = 1'b1; r0_va = 24'h00DEAD;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (walk_req) seen = 1'b1;
    end
    chk("rstwalk_reached_walk", {31'd0, seen}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstwalk_walk_req", walk_req, 32'd0);
    chk("rstwalk_busy", busy, 32'd0);
    chk("rstwalk_acks", {30'd0, r1_ack, r0_ack}, 32'd0);
    chk("rstwalk_mmu_va", mmu_va, 32'd0);
    r0_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hit_v = 1'b1;
    r1_req = 1'b1; r1_va = 24'h00C0DE; r1_fc = FC_SUP_DATA; r1_rw_n = 1'b0;
    run_txn(5, 1'b0, cyc, a0, a1, pa, flt, walks, fw, lva, lfc, lrw);
    r1_req = 1'b0;
    chk("post_rst_who", {30'd0, a1, a0}, 32'd2);
    chk("post_rst_lat", cyc, 32'd3);
    chk("post_rst_pa", pa, 32'h0AC0DE);
    chk("post_rst_fault", flt, 32'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
